// File: rtl/key_expander.sv
// AES key schedule: latches a 128/192/256-bit key, expands one word per cycle, and serves round keys combinationally.
// Accepts a load in IDLE/DONE; rejected loads pulse err; loads during EXPAND are ignored.
module aes_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   always_comb begin
      logic [7:0] sq;
      logic [7:0] inv;
      // inverse is x^254 = product of x^2 .. x^128; zero maps to zero
      sq  = din;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

module key_expander #(
   parameter int AES256_EN = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [1:0]   key_len,
   input  logic [255:0] key_in,
   output logic         busy,
   output logic         keys_ready,
   output logic         done,
   output logic         err,
   input  logic [3:0]   rd_round,
   output logic [127:0] rd_key,
   output logic         rd_valid
);
   localparam int NW = (AES256_EN != 0) ? 60 : 52;

   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] w [NW];
   logic [5:0]  i;
   logic [3:0]  nk;
   logic [2:0]  kcnt;
   logic [7:0]  rcon;
   logic        accept, reject, legal, last;
   logic [3:0]  nk_new;
   logic [31:0] prev, sub_in, sub_out, t, w_new;
   logic [5:0]  ridx;

   assign legal = (key_len == 2'd0) || (key_len == 2'd1) || ((key_len == 2'd2) && (AES256_EN != 0));
   assign nk_new = (key_len == 2'd0) ? 4'd4 : (key_len == 2'd1) ? 4'd6 : 4'd8;
   assign last = (i == ({nk, 2'b00} + 6'd27));

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      reject    = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (load_valid) begin
               if (legal) begin
                  accept    = 1'b1;
                  state_nxt = EXPAND;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         EXPAND: if (last) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         i          <= '0;
         nk         <= '0;
         kcnt       <= '0;
         rcon       <= '0;
         keys_ready <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         err   <= reject;
         if (accept) begin
            nk         <= nk_new;
            i          <= {2'b00, nk_new};
            kcnt       <= '0;
            rcon       <= 8'h01;
            keys_ready <= 1'b0;
         end else if (state == EXPAND) begin
            i    <= i + 6'd1;
            kcnt <= ({1'b0, kcnt} == nk - 4'd1) ? 3'd0 : kcnt + 3'd1;
            // Rcon advances by xtime after each use: 80 -> 1b -> 36
            if (kcnt == 3'd0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            if (last) begin
               keys_ready <= 1'b1;
               done       <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (accept) begin
            for (int k = 0; k < 8; k++) w[k] <= key_in[255 - 32*k -: 32];
         end else if (state == EXPAND) begin
            w[i] <= w_new;
         end
      end
   end

   assign prev   = w[i - 6'd1];
   assign sub_in = (kcnt == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

   aes_sbox u_sb3 (.din(sub_in[31:24]), .dout(sub_out[31:24]));
   aes_sbox u_sb2 (.din(sub_in[23:16]), .dout(sub_out[23:16]));
   aes_sbox u_sb1 (.din(sub_in[15:8]),  .dout(sub_out[15:8]));
   aes_sbox u_sb0 (.din(sub_in[7:0]),   .dout(sub_out[7:0]));

   always_comb begin
      t = prev;
      if (kcnt == 3'd0)                          t = sub_out ^ {rcon, 24'h0};
      else if ((nk == 4'd8) && (kcnt == 3'd4))   t = sub_out;
   end

   assign w_new = w[i - {2'b00, nk}] ^ t;

   assign load_ready = (state != EXPAND);
   assign busy       = (state == EXPAND);
   assign rd_valid   = keys_ready && ({1'b0, rd_round} <= ({1'b0, nk} + 5'd6));
   assign ridx       = {rd_round, 2'b00};
   assign rd_key     = rd_valid ? {w[ridx], w[ridx + 6'd1], w[ridx + 6'd2], w[ridx + 6'd3]} : 128'h0;
endmodule

// File: tb/tb_key_expander.sv
// Randomized and known-answer bench for key_expander against a table-driven FIPS-197 key schedule model.
module tb_key_expander;
   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   logic         clk = 1'b0;
   logic         rst;
   logic         load_valid, load_valid_b;
   logic [1:0]   key_len, key_len_b;
   logic [255:0] key_in;
   logic [3:0]   rd_round;
   logic         load_ready, busy, keys_ready, done, err, rd_valid;
   logic [127:0] rd_key;
   logic         load_ready_b, busy_b, keys_ready_b, done_b, err_b, rd_valid_b;
   logic [127:0] rd_key_b;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  ex_t [0:255];
   int          lg_t [0:255];
   logic [7:0]  rc   [1:10];
   logic [31:0] ref_w [0:59];

   always #5 clk = ~clk;

   key_expander #(.AES256_EN(1)) u_dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .key_len(key_len), .key_in(key_in), .busy(busy), .keys_ready(keys_ready),
      .done(done), .err(err), .rd_round(rd_round), .rd_key(rd_key), .rd_valid(rd_valid)
   );

   key_expander #(.AES256_EN(0)) u_dut_b (
      .clk(clk), .rst(rst), .load_valid(load_valid_b), .load_ready(load_ready_b),
      .key_len(key_len_b), .key_in(key_in), .busy(busy_b), .keys_ready(keys_ready_b),
      .done(done_b), .err(err_b), .rd_round(rd_round), .rd_key(rd_key_b), .rd_valid(rd_valid_b)
   );

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = (b << n) | (b >> (8 - n));
      return r;
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] b;
      b = (x == 8'h00) ? 8'h00 : ex_t[(255 - lg_t[x]) % 255];
      return b ^ rol8(b, 1) ^ rol8(b, 2) ^ rol8(b, 3) ^ rol8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] v);
      return {sbox_ref(v[31:24]), sbox_ref(v[23:16]), sbox_ref(v[15:8]), sbox_ref(v[7:0])};
   endfunction

   task automatic build_tables();
      logic [7:0] p;
      p = 8'h01;
      for (int k = 0; k < 255; k++) begin
         ex_t[k] = p;
         lg_t[p] = k;
         p = p ^ xt(p);
      end
      ex_t[255] = 8'h01;
      rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
   endtask

   task automatic model_expand(input logic [255:0] key, input int nk);
      logic [31:0] t;
      int total;
      total = 4 * (nk + 7);
      for (int k = 0; k < nk; k++) ref_w[k] = key[255 - 32*k -: 32];
      for (int k = nk; k < total; k++) begin
         t = ref_w[k-1];
         if (k % nk == 0)                 t = sub_word({t[23:0], t[31:24]}) ^ {rc[k/nk], 24'h0};
         else if (nk == 8 && k % 8 == 4)  t = sub_word(t);
         ref_w[k] = ref_w[k-nk] ^ t;
      end
   endtask

   function automatic logic [255:0] rand_key();
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r = {r[223:0], 32'($urandom)};
      return r;
   endfunction

   task automatic read_check(input int r, input logic [127:0] exp, input string tag);
      rd_round = 4'(r);
      #1;
      check_val({tag, "_rd_valid"}, 128'(rd_valid), 128'(1));
      check_val({tag, "_rd_key"}, rd_key, exp);
   endtask

   // Loads a key, optionally pokes load_valid mid-expansion, then checks timing and every round key.
   task automatic expand_and_check(input logic [1:0] len, input logic [255:0] key,
                                   input int mid_load_at, input string tag);
      int nk, nr, cyc;
      logic err_seen;
      nk = (len == 2'd0) ? 4 : (len == 2'd1) ? 6 : 8;
      nr = nk + 6;
      model_expand(key, nk);
      @(negedge clk);
      load_valid = 1'b1;
      key_len    = len;
      key_in     = key;
      @(posedge clk);
      #1;
      load_valid = 1'b0;
      key_in     = rand_key();
      key_len    = 2'($urandom);
      check_val({tag, "_busy_on_accept"}, 128'(busy), 128'(1));
      check_val({tag, "_kr_drop"}, 128'(keys_ready), 128'(0));
      check_val({tag, "_load_ready_exp"}, 128'(load_ready), 128'(0));
      cyc = 0;
      err_seen = 1'b0;
      while (!done && cyc < 200) begin
         if (cyc == mid_load_at) load_valid = 1'b1;
         @(posedge clk);
         #1;
         cyc++;
         load_valid = 1'b0;
         if (err) err_seen = 1'b1;
      end
      check_val({tag, "_expand_cycles"}, 128'(cyc), 128'(4 * (nr + 1) - nk));
      check_val({tag, "_keys_ready"}, 128'(keys_ready), 128'(1));
      check_val({tag, "_busy_done"}, 128'(busy), 128'(0));
      if (mid_load_at >= 0) check_val({tag, "_mid_load_err"}, 128'(err_seen), 128'(0));
      @(posedge clk);
      #1;
      check_val({tag, "_done_pulse"}, 128'(done), 128'(0));
      for (int r = 0; r <= nr; r++)
         read_check(r, {ref_w[4*r], ref_w[4*r+1], ref_w[4*r+2], ref_w[4*r+3]}, $sformatf("%s_r%0d", tag, r));
      if (nr < 15) begin
         rd_round = 4'(nr + 1);
         #1;
         check_val({tag, "_past_nr_valid"}, 128'(rd_valid), 128'(0));
         check_val({tag, "_past_nr_key"}, rd_key, 128'(0));
      end
   endtask

   initial begin
      int cyc;
      build_tables();
      rst = 1'b1; load_valid = 1'b0; load_valid_b = 1'b0;
      key_len = '0; key_len_b = '0; key_in = '0; rd_round = '0;
      repeat (2) @(posedge clk);
      #1;
      check_val("rst_load_ready", 128'(load_ready), 128'(1));
      check_val("rst_busy", 128'(busy), 128'(0));
      check_val("rst_keys_ready", 128'(keys_ready), 128'(0));
      check_val("rst_done", 128'(done), 128'(0));
      check_val("rst_err", 128'(err), 128'(0));
      check_val("rst_rd_valid", 128'(rd_valid), 128'(0));
      check_val("rst_rd_key", rd_key, 128'(0));
      @(negedge clk);
      rst = 1'b0;

      // illegal length in IDLE
      @(negedge clk);
      load_valid = 1'b1; key_len = 2'd3; key_in = rand_key();
      @(posedge clk); #1;
      load_valid = 1'b0;
      check_val("len3_err", 128'(err), 128'(1));
      check_val("len3_busy", 128'(busy), 128'(0));
      check_val("len3_load_ready", 128'(load_ready), 128'(1));
      check_val("len3_keys_ready", 128'(keys_ready), 128'(0));
      @(posedge clk); #1;
      check_val("len3_err_one_cycle", 128'(err), 128'(0));

      // 256-bit disabled instance
      @(negedge clk);
      load_valid_b = 1'b1; key_len_b = 2'd2; key_in = K256;
      @(posedge clk); #1;
      load_valid_b = 1'b0;
      check_val("no256_err", 128'(err_b), 128'(1));
      check_val("no256_busy", 128'(busy_b), 128'(0));
      @(negedge clk);
      load_valid_b = 1'b1; key_len_b = 2'd0; key_in = K128;
      @(posedge clk); #1;
      load_valid_b = 1'b0;
      check_val("no256_128_busy", 128'(busy_b), 128'(1));
      cyc = 0;
      while (!done_b && cyc < 200) begin @(posedge clk); #1; cyc++; end
      check_val("no256_128_cycles", 128'(cyc), 128'(40));
      rd_round = 4'd10; #1;
      check_val("no256_128_r10", rd_key_b, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      expand_and_check(2'd0, K128, -1, "aes128");
      read_check(0, K128[255:128], "kat128_r0");
      read_check(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "kat128_r10");
      rd_round = 4'd11; #1;
      check_val("kat128_r11_valid", 128'(rd_valid), 128'(0));

      expand_and_check(2'd1, K192, -1, "aes192");
      read_check(12, 128'he98ba06f448c773c8ecc720401002202, "kat192_r12");

      expand_and_check(2'd2, K256, 10, "aes256");
      read_check(14, 128'hfe4890d1e6188d0b046df344706c631e, "kat256_r14");

      // reset during EXPAND cycle 20, with a competing load
      @(negedge clk);
      load_valid = 1'b1; key_len = 2'd0; key_in = rand_key();
      @(posedge clk); #1;
      load_valid = 1'b0;
      repeat (19) begin @(posedge clk); #1; end
      check_val("mid_rst_still_busy", 128'(busy), 128'(1));
      rst = 1'b1; load_valid = 1'b1; key_len = 2'd0; rd_round = 4'd0;
      @(posedge clk); #1;
      rst = 1'b0; load_valid = 1'b0;
      check_val("mid_rst_busy", 128'(busy), 128'(0));
      check_val("mid_rst_load_ready", 128'(load_ready), 128'(1));
      check_val("mid_rst_keys_ready", 128'(keys_ready), 128'(0));
      check_val("mid_rst_rd_valid", 128'(rd_valid), 128'(0));
      check_val("mid_rst_rd_key", rd_key, 128'(0));
      check_val("mid_rst_done", 128'(done), 128'(0));
      expand_and_check(2'd0, K128, -1, "post_rst128");
      read_check(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "post_rst_r10");

      // reload from DONE with a different key, then back to the known vector
      expand_and_check(2'd0, rand_key(), -1, "reload_rand");
      expand_and_check(2'd0, K128, -1, "reload_kat");
      read_check(10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "reload_kat_r10");

      for (int n = 0; n < 6; n++)
         expand_and_check(2'($urandom_range(0, 2)), rand_key(), (n % 2 == 1) ? int'($urandom_range(0, 30)) : -1,
                          $sformatf("rnd%0d", n));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
